recv_frame: RTL and testbench
=============================

Name: recv_frame

Overview:
- Receive-side frame decoder for the GTP link. It sits between the GTP RX user interface (comma-aligned 32-bit data plus per-byte K flags) and the local RX buffer.
- It parses two-word frames, checks their checksum and tracks sequence numbers.
- Good data payloads are written to the RX buffer. An ack/nack word goes to the local transmitter for echo back to the far end.
- Control frames are decoded into a remote buffer-status word and an ack-info word, which feed the local transmitter's flow control.

Parameters:
- COMMA, 8'hBC: K28.5 byte, header byte0.
- HEAD_DATA, 8'h55: header byte1 for a data frame.
- HEAD_CTRL, 8'hAA: header byte1 for a control frame.
- ERR_W, 16: width of the frame error counter.

Ports:
- rx_clk, in, 1: GTP RX user clock. This is the only clock.
- ap_rst_n, in, 1: asynchronous active-low reset.
- gtp_rxdata, in, 32: received word.
- gtp_rxctl, in, 4: per-byte K flags; bit0 pairs with byte0.
- rx_full, in, 1: RX buffer cannot accept a word.
- rx_wren, out, 1: write strobe to the RX buffer.
- rx_wrdata, out, 32: payload written to the RX buffer.
- send_back_flag, out, 1: one-cycle pulse asking the local TX to send an ack.
- send_back_data, out, 16: ack word {seq[7:0], 1'b0, ok, 6'b0}.
- send_info_vaild, out, 1: one-cycle pulse; an ack was received from the far end.
- send_info, out, 16: received ack word.
- remote_statue_vaild, out, 1: one-cycle pulse; a remote buffer status was received.
- remote_statue, out, 16: far-end buffer status.
- frame_err_cnt, out, ERR_W: saturating count of rejected frames.

Behaviour:
- Frame format:
  - Word0 is {sum[7:0], seq[7:0], type[7:0], COMMA} with gtp_rxctl=4'b0001.
  - Word1 is the payload P[31:0] with gtp_rxctl=4'b0000.
  - The expected sum is (P[23:16]+P[7:0]) mod 256.
- A control frame is a back frame when P[3:0]==4'h1; otherwise it is a status frame.
- All outputs reset to 0. In particular, last_seq resets to 8'hFF with seq_valid=0.
- State machine:
  - S_HUNT: wait for a header. A header is rxctl==4'b0001, byte0==COMMA and byte1 in {HEAD_DATA, HEAD_CTRL}. On a header, latch sum, seq and type, then go to S_PAYLOAD.
  - S_HUNT, any other word: idle fill, stay in S_HUNT with no error.
  - S_PAYLOAD, rxctl==0: latch P and go to S_CHECK.
  - S_PAYLOAD, rxctl!=0: the frame is truncated. Increment the error counter.
    - If the word is itself a valid header, latch it and stay in S_PAYLOAD.
    - Otherwise go to S_HUNT.
  - S_CHECK: exactly one cycle. Compare the sum, drive the outputs, return to S_HUNT.
    - A header arriving in this cycle is latched and the FSM goes straight to S_PAYLOAD.
    - Back-to-back frames are therefore lossless.
- Latency: every output pulse is asserted in the cycle after S_CHECK, i.e. 2 cycles after the payload word is presented. Each pulse lasts exactly 1 cycle.
- Data frame, checksum good, seq != last_seq or !seq_valid, and !rx_full:
  - rx_wren=1, rx_wrdata=P.
  - Update last_seq=seq and set seq_valid=1.
  - Send an ack with ok=1.
- Data frame, checksum good, seq==last_seq and seq_valid (retransmission): no write; ack with ok=1.
- Data frame, checksum good, rx_full sampled in S_CHECK: no write, last_seq unchanged, ack with ok=0.
- Data frame, checksum bad: no write, ack with ok=0, error counter +1.
- Control frame, checksum good: remote_statue_vaild=1 and remote_statue=P[31:16] (both frame kinds).
  - Back frame only: additionally send_info_vaild=1, send_info=P[15:0].
- Control frame, checksum bad: discard the frame, error counter +1, no pulses.
- Sequence compare is plain 8-bit equality, so 8'hFF→8'h00 wrap-around is not special.
- Error counter saturates at all ones.
- Asserting reset mid-frame aborts the frame immediately, with no partial pulse, and the FSM returns to S_HUNT.

Decomposition:
- Shared package gtp_frame_pkg holds:
  - COMMA, HEAD_DATA, HEAD_CTRL;
  - the K-flag pattern 4'b0001 and the back-frame tag 4'h1;
  - ack-word bit positions: seq [15:8], ok bit 6;
  - a function frame_sum(P).
- The matching send_frame uses the same package.
- No sub-module: a single FSM plus an output register stage.

Test Plan:
- Data frame: 0xAC0555BC/ctl 1, then 0x12345678/ctl 0 → rx_wren with rx_wrdata=0x12345678; send_back_flag with send_back_data=0x0540; error count stays 0.
- Repeat the same frame → no rx_wren; send_back_data=0x0540 again.
- Send 0x00065555BC… i.e. header 0x000655BC (seq 6, wrong sum), then 0x12345678 → no write; send_back_data=0x0600; frame_err_cnt=1.
- Send header 0x3102AABC, then 0x00F00541 → send_info_vaild with send_info=0x0541; remote_statue_vaild with remote_statue=0x00F0.
- Status frame: header 0x2003AABC, then 0x00200000 → remote_statue=0x0020; no send_info_vaild.
- Two frames back-to-back with no idle gap, seq 7 then 8 → two writes and acks 0x0740 and 0x0840.
- Also cover these cases:
  - header then header → error counter +1 and the second frame is still accepted;
  - rx_full=1 → ack 0x0700 (ok=0) and no write;
  - reset between word0 and word1 → no pulses.

Source files
------------

// File: rtl/gtp_frame_pkg.sv
// Shared GTP link framing constants and helpers, used by recv_frame and send_frame.
package gtp_frame_pkg;

  localparam logic [7:0] COMMA     = 8'hBC;
  localparam logic [7:0] HEAD_DATA = 8'h55;
  localparam logic [7:0] HEAD_CTRL = 8'hAA;

  localparam logic [3:0] K_HEAD   = 4'b0001;
  localparam logic [3:0] BACK_TAG = 4'h1;

  // Ack word layout: {seq[7:0], 1'b0, ok, 6'b0}
  localparam int unsigned ACK_SEQ_LSB = 8;
  localparam int unsigned ACK_OK_BIT  = 6;

  typedef enum logic [1:0] {StHunt, StPayload, StCheck} rx_state_e;

  function automatic logic [7:0] frame_sum(input logic [31:0] p);
    return p[23:16] + p[7:0];
  endfunction

endpackage

// File: rtl/recv_frame.sv
// GTP receive-side frame decoder: parses header/payload pairs, checks the sum, filters
// retransmissions and emits RX-buffer writes, ack requests and remote flow-control info.
module recv_frame
  import gtp_frame_pkg::*;
#(
  parameter int unsigned ERR_W = 16
) (
  input  logic             rx_clk,
  input  logic             ap_rst_n,
  input  logic [31:0]      gtp_rxdata,
  input  logic [3:0]       gtp_rxctl,
  input  logic             rx_full,
  output logic             rx_wren,
  output logic [31:0]      rx_wrdata,
  output logic             send_back_flag,
  output logic [15:0]      send_back_data,
  output logic             send_info_vaild,
  output logic [15:0]      send_info,
  output logic             remote_statue_vaild,
  output logic [15:0]      remote_statue,
  output logic [ERR_W-1:0] frame_err_cnt
);

  rx_state_e state_q, state_d;

  logic [7:0]  sum_q, seq_q, type_q, last_seq_q;
  logic [31:0] pay_q;
  logic        seq_valid_q;

  logic        is_head, pay_load, trunc, sum_bad, err_inc, seq_upd;
  logic        wren_d, ack_d, ack_ok, info_d, stat_d;
  logic [15:0] ack_word;

  assign is_head = (gtp_rxctl == K_HEAD) && (gtp_rxdata[7:0] == COMMA) &&
                   ((gtp_rxdata[15:8] == HEAD_DATA) || (gtp_rxdata[15:8] == HEAD_CTRL));

  always_ff @(posedge rx_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= StHunt;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = StHunt;
    case (state_q)
      StHunt:    state_d = is_head ? StPayload : StHunt;
      StPayload: begin
        if (gtp_rxctl == 4'b0000) state_d = StCheck;
        else if (is_head)         state_d = StPayload;
        else                      state_d = StHunt;
      end
      StCheck:   state_d = is_head ? StPayload : StHunt;
      default:   state_d = StHunt;
    endcase
  end

  always_comb begin
    pay_load = 1'b0;
    trunc    = 1'b0;
    sum_bad  = 1'b0;
    seq_upd  = 1'b0;
    wren_d   = 1'b0;
    ack_d    = 1'b0;
    ack_ok   = 1'b0;
    info_d   = 1'b0;
    stat_d   = 1'b0;
    case (state_q)
      StPayload: begin
        pay_load = (gtp_rxctl == 4'b0000);
        trunc    = !pay_load;
      end
      StCheck: begin
        if (frame_sum(pay_q) != sum_q) begin
          sum_bad = 1'b1;
          ack_d   = (type_q == HEAD_DATA);
        end else if (type_q == HEAD_DATA) begin
          ack_d = 1'b1;
          // A retransmission is acked as good even when the buffer is full.
          if (seq_valid_q && (seq_q == last_seq_q)) begin
            ack_ok = 1'b1;
          end else if (!rx_full) begin
            ack_ok  = 1'b1;
            wren_d  = 1'b1;
            seq_upd = 1'b1;
          end
        end else begin
          stat_d = 1'b1;
          info_d = (pay_q[3:0] == BACK_TAG);
        end
      end
      default: ;
    endcase
    err_inc  = trunc | sum_bad;
    ack_word = '0;
    ack_word[ACK_SEQ_LSB +: 8] = seq_q;
    ack_word[ACK_OK_BIT]       = ack_ok;
  end

  always_ff @(posedge rx_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sum_q       <= '0;
      seq_q       <= '0;
      type_q      <= '0;
      pay_q       <= '0;
      last_seq_q  <= 8'hFF;
      seq_valid_q <= 1'b0;
    end else begin
      if (is_head) begin
        sum_q  <= gtp_rxdata[31:24];
        seq_q  <= gtp_rxdata[23:16];
        type_q <= gtp_rxdata[15:8];
      end
      if (pay_load) pay_q <= gtp_rxdata;
      if (seq_upd) begin
        last_seq_q  <= seq_q;
        seq_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge rx_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rx_wren             <= 1'b0;
      rx_wrdata           <= '0;
      send_back_flag      <= 1'b0;
      send_back_data      <= '0;
      send_info_vaild     <= 1'b0;
      send_info           <= '0;
      remote_statue_vaild <= 1'b0;
      remote_statue       <= '0;
      frame_err_cnt       <= '0;
    end else begin
      rx_wren             <= wren_d;
      send_back_flag      <= ack_d;
      send_info_vaild     <= info_d;
      remote_statue_vaild <= stat_d;
      if (wren_d) rx_wrdata      <= pay_q;
      if (ack_d)  send_back_data <= ack_word;
      if (info_d) send_info      <= pay_q[15:0];
      if (stat_d) remote_statue  <= pay_q[31:16];
      if (err_inc && (frame_err_cnt != {ERR_W{1'b1}})) frame_err_cnt <= frame_err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_recv_frame.sv
// Self-checking bench for recv_frame: frame-level reference model plus directed scenarios.
module tb_recv_frame;

  logic        rx_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [31:0] gtp_rxdata = '0;
  logic [3:0]  gtp_rxctl = '0;
  logic        rx_full = 1'b0;
  logic        rx_wren, send_back_flag, send_info_vaild, remote_statue_vaild;
  logic [31:0] rx_wrdata;
  logic [15:0] send_back_data, send_info, remote_statue, frame_err_cnt;

  recv_frame #(.ERR_W(16)) dut (
    .rx_clk              (rx_clk),
    .ap_rst_n            (ap_rst_n),
    .gtp_rxdata          (gtp_rxdata),
    .gtp_rxctl           (gtp_rxctl),
    .rx_full             (rx_full),
    .rx_wren             (rx_wren),
    .rx_wrdata           (rx_wrdata),
    .send_back_flag      (send_back_flag),
    .send_back_data      (send_back_data),
    .send_info_vaild     (send_info_vaild),
    .send_info           (send_info),
    .remote_statue_vaild (remote_statue_vaild),
    .remote_statue       (remote_statue),
    .frame_err_cnt       (frame_err_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Frame-level model state
  bit          m_have_hdr, m_pend, m_valid;
  logic [7:0]  m_sum, m_seq, m_type, m_last;
  logic [31:0] m_pay;
  int          m_err;
  // Expected outputs at the next sample point
  bit          e_wren, e_ack, e_info, e_stat;
  logic [31:0] e_wrdata;
  logic [15:0] e_ackd, e_infod, e_statd;

  logic [31:0] wr_log[$];
  logic [15:0] ack_log[$], info_log[$], stat_log[$];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_have_hdr = 0; m_pend = 0; m_valid = 0; m_last = 8'hFF; m_err = 0;
    m_sum = 0; m_seq = 0; m_type = 0; m_pay = 0;
    e_wren = 0; e_ack = 0; e_info = 0; e_stat = 0;
    e_wrdata = 0; e_ackd = 0; e_infod = 0; e_statd = 0;
  endtask

  function automatic bit is_hdr(input logic [31:0] d, input logic [3:0] c);
    return (c == 4'b0001) && (d[7:0] == 8'hBC) && (d[15:8] == 8'h55 || d[15:8] == 8'hAA);
  endfunction

  task automatic bump_err();
    if (m_err < 65535) m_err++;
  endtask

  // Consumes one input word; 'full' is the buffer state in this cycle.
  task automatic model_step(input logic [31:0] d, input logic [3:0] c, input bit full);
    int s;
    bit ok;
    e_wren = 0; e_ack = 0; e_info = 0; e_stat = 0;
    if (m_pend) begin
      s = (int'(m_pay[23:16]) + int'(m_pay[7:0])) % 256;
      if (m_type == 8'h55) begin
        e_ack = 1;
        ok = 0;
        if (s != int'(m_sum)) bump_err();
        else if (m_valid && m_seq == m_last) ok = 1;
        else if (!full) begin
          ok = 1; e_wren = 1; e_wrdata = m_pay; m_last = m_seq; m_valid = 1;
        end
        e_ackd = {m_seq, 8'h00} | (ok ? 16'h0040 : 16'h0000);
      end else begin
        if (s == int'(m_sum)) begin
          e_stat = 1; e_statd = m_pay[31:16];
          if (m_pay[3:0] == 4'h1) begin e_info = 1; e_infod = m_pay[15:0]; end
        end else bump_err();
      end
      m_pend = 0;
    end
    if (m_have_hdr && c == 4'b0000) begin
      m_pend = 1; m_pay = d; m_have_hdr = 0;
    end else begin
      if (m_have_hdr) bump_err();
      m_have_hdr = is_hdr(d, c);
      if (m_have_hdr) begin m_sum = d[31:24]; m_seq = d[23:16]; m_type = d[15:8]; end
    end
  endtask

  task automatic check();
    cmp("rx_wren", rx_wren, e_wren);
    if (e_wren) cmp("rx_wrdata", rx_wrdata, e_wrdata);
    cmp("send_back_flag", send_back_flag, e_ack);
    if (e_ack) cmp("send_back_data", send_back_data, e_ackd);
    cmp("send_info_vaild", send_info_vaild, e_info);
    if (e_info) cmp("send_info", send_info, e_infod);
    cmp("remote_statue_vaild", remote_statue_vaild, e_stat);
    if (e_stat) cmp("remote_statue", remote_statue, e_statd);
    cmp("frame_err_cnt", frame_err_cnt, m_err);
    if (rx_wren) wr_log.push_back(rx_wrdata);
    if (send_back_flag) ack_log.push_back(send_back_data);
    if (send_info_vaild) info_log.push_back(send_info);
    if (remote_statue_vaild) stat_log.push_back(remote_statue);
  endtask

  task automatic cycle(input logic [31:0] d, input logic [3:0] c);
    @(negedge rx_clk);
    check();
    gtp_rxdata = d;
    gtp_rxctl  = c;
    if (!ap_rst_n) model_reset();
    else model_step(d, c, rx_full);
  endtask

  task automatic frame(input logic [31:0] hdr, input logic [31:0] pay);
    cycle(hdr, 4'b0001);
    cycle(pay, 4'b0000);
  endtask

  task automatic idle2();
    cycle(32'h0, 4'b0000);
    cycle(32'h0, 4'b0000);
  endtask

  task automatic clr();
    wr_log.delete(); ack_log.delete(); info_log.delete(); stat_log.delete();
  endtask

  // Literal expectations on what the DUT emitted during one scenario.
  task automatic logs(input string tag, input int n_wr, input logic [31:0] w0, input logic [31:0] w1,
                      input int n_ack, input logic [15:0] a0, input logic [15:0] a1,
                      input int n_info, input logic [15:0] i0, input int n_stat,
                      input logic [15:0] s0, input int err);
    cmp({tag, ".writes"}, wr_log.size(), n_wr);
    if (n_wr > 0 && wr_log.size() > 0) cmp({tag, ".wr0"}, wr_log[0], w0);
    if (n_wr > 1 && wr_log.size() > 1) cmp({tag, ".wr1"}, wr_log[1], w1);
    cmp({tag, ".acks"}, ack_log.size(), n_ack);
    if (n_ack > 0 && ack_log.size() > 0) cmp({tag, ".ack0"}, ack_log[0], a0);
    if (n_ack > 1 && ack_log.size() > 1) cmp({tag, ".ack1"}, ack_log[1], a1);
    cmp({tag, ".infos"}, info_log.size(), n_info);
    if (n_info > 0 && info_log.size() > 0) cmp({tag, ".info0"}, info_log[0], i0);
    cmp({tag, ".stats"}, stat_log.size(), n_stat);
    if (n_stat > 0 && stat_log.size() > 0) cmp({tag, ".stat0"}, stat_log[0], s0);
    cmp({tag, ".err"}, frame_err_cnt, err);
    clr();
  endtask

  initial begin
    model_reset();
    cycle(32'h0, 4'b0000);
    cycle(32'h0, 4'b0000);
    cmp("rst.rx_wrdata", rx_wrdata, 32'h0);
    cmp("rst.send_back_data", send_back_data, 16'h0);
    cmp("rst.send_info", send_info, 16'h0);
    cmp("rst.remote_statue", remote_statue, 16'h0);
    ap_rst_n = 1'b1;
    idle2();
    clr();

    // seq FF first after reset (seq_valid clear), then wrap to 00
    frame(32'h00FF55BC, 32'h0); idle2();
    logs("seq_ff", 1, 32'h0, 0, 1, 16'hFF40, 0, 0, 0, 0, 0, 0);
    frame(32'h000055BC, 32'h0); idle2();
    logs("seq_00", 1, 32'h0, 0, 1, 16'h0040, 0, 0, 0, 0, 0, 0);

    frame(32'hAC0555BC, 32'h12345678); idle2();
    logs("data", 1, 32'h12345678, 0, 1, 16'h0540, 0, 0, 0, 0, 0, 0);
    frame(32'hAC0555BC, 32'h12345678); idle2();
    logs("retx", 0, 0, 0, 1, 16'h0540, 0, 0, 0, 0, 0, 0);
    frame(32'h000655BC, 32'h12345678); idle2();
    logs("badsum", 0, 0, 0, 1, 16'h0600, 0, 0, 0, 0, 0, 1);

    // Idle fill that looks K-ish but is not a header
    cycle(32'h000000BC, 4'b0001);
    cycle(32'h0000AABC, 4'b0011);
    idle2();
    logs("fill", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    frame(32'h3102AABC, 32'h00F00541); idle2();
    logs("back", 0, 0, 0, 0, 0, 0, 1, 16'h0541, 1, 16'h00F0, 1);
    frame(32'h2003AABC, 32'h00200000); idle2();
    logs("status", 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0020, 1);
    frame(32'h0003AABC, 32'h00200000); idle2();
    logs("ctrl_bad", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    rx_full = 1'b1;
    frame(32'h070755BC, 32'h00000007); idle2();
    rx_full = 1'b0;
    logs("full", 0, 0, 0, 1, 16'h0700, 0, 0, 0, 0, 0, 2);

    frame(32'h070755BC, 32'h00000007);
    frame(32'h330855BC, 32'h00110022);
    idle2();
    logs("b2b", 2, 32'h00000007, 32'h00110022, 2, 16'h0740, 16'h0840, 0, 0, 0, 0, 2);

    cycle(32'h030955BC, 4'b0001);
    frame(32'h030955BC, 32'h00010002); idle2();
    logs("hdr_hdr", 1, 32'h00010002, 0, 1, 16'h0940, 0, 0, 0, 0, 0, 3);

    // Reset lands after the header has been latched
    cycle(32'h000A55BC, 4'b0001);
    @(posedge rx_clk);
    #2;
    ap_rst_n = 1'b0;
    model_reset();
    cycle(32'h0, 4'b0000);
    cycle(32'h0, 4'b0000);
    ap_rst_n = 1'b1;
    idle2();
    logs("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    frame(32'h000A55BC, 32'h0); idle2();
    logs("post_rst", 1, 32'h0, 0, 1, 16'h0A40, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
